// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Brief    : Shared constants, types and the block/row address mapping for
//             the inter MC row fetcher.
//  Revision : 1.0  initial release
// ============================================================================
package mc_pkg;

  localparam int PIX_W        = 8;
  localparam int ROW_W        = 4 * PIX_W;
  localparam int N_LUMA_BLK   = 16;
  localparam int N_CHROMA_BLK = 8;
  localparam int N_BLK        = N_LUMA_BLK + N_CHROMA_BLK;
  localparam int N_ROWS       = 4 * N_BLK;
  localparam int ADDR_W       = 7;

  localparam logic [ADDR_W-1:0] LUMA_BASE = 7'd0;
  localparam logic [ADDR_W-1:0] CB_BASE   = 7'd64;
  localparam logic [ADDR_W-1:0] CR_BASE   = 7'd80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } mc_state_e;

  // Side-band information that travels with every row read.
  typedef struct packed {
    logic [1:0] row;
    logic [4:0] blk;
    logic       ccin;
    logic       last;
  } row_tag_t;

  // Buffer address of row r of block b in H.264 4x4 block-scan order.
  // Luma: 16x16 plane, 4 words per pixel row. Chroma: two 8x8 planes,
  // 2 words per pixel row, Cb first then Cr.
  function automatic logic [ADDR_W-1:0] blk_row_addr(input logic [4:0] b,
                                                     input logic [1:0] r);
    logic [ADDR_W-1:0] bx;
    logic [ADDR_W-1:0] by;
    logic [ADDR_W-1:0] rr;
    logic [ADDR_W-1:0] addr;
    rr = {{(ADDR_W-2){1'b0}}, r};
    if (b < 5'(N_LUMA_BLK)) begin
      bx   = {{(ADDR_W-2){1'b0}}, b[2], b[0]};
      by   = {{(ADDR_W-2){1'b0}}, b[3], b[1]};
      addr = LUMA_BASE + ((((by << 2) + rr)) << 2) + bx;
    end else begin
      // For b in 16..23 the chroma index c = b - 16 has c[2:0] == b[2:0].
      bx   = {{(ADDR_W-1){1'b0}}, b[0]};
      by   = {{(ADDR_W-1){1'b0}}, b[1]};
      addr = (b[2] ? CR_BASE : CB_BASE) + (((by << 2) + rr) << 1) + bx;
    end
    return addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_row_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mc_row_fifo
//  Brief    : Two-entry FIFO holding a current/prediction row pair plus tag.
//  Revision : 1.0  initial release
// ============================================================================
module mc_row_fifo
  import mc_pkg::*;
#(
  parameter int DATA_W = 2 * ROW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  row_tag_t          i_push_tag,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_pop_data,
  output row_tag_t          o_pop_tag,
  output logic [1:0]        o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_data [2];
  row_tag_t          r_tag  [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is only legal when the head leaves this cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_pop_data = r_data[r_rd_ptr];
  assign o_pop_tag  = r_tag[r_rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage; contents are meaningless while the slot is empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_data[r_wr_ptr] <= i_push_data;
      r_tag[r_wr_ptr]  <= i_push_tag;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mc_row_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : mc_row_fetch
//  Brief    : Walks one macroblock's 24 4x4 blocks row by row, reads the
//             current and prediction buffers at a shared address and hands
//             the rows to the MC controller over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module mc_row_fetch
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [ROW_W-1:0]  cur_rdata,
  input  logic [ROW_W-1:0]  ref_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_cur,
  output logic [ROW_W-1:0]  out_ref,
  output logic [1:0]        out_row,
  output logic [4:0]        out_blk,
  output logic              out_ccin,
  output logic              out_last
);

  mc_state_e          r_state;
  logic [1:0]         r_row;
  logic [4:0]         r_blk;
  logic               r_inflight;
  row_tag_t           r_if_tag;

  row_tag_t           w_issue_tag;
  row_tag_t           w_head_tag;
  logic [2*ROW_W-1:0] w_head_data;
  logic [1:0]         w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_pop;
  logic               w_room;
  logic [2:0]         w_occ;
  logic               w_issue;
  logic               w_done;
  logic               w_last_issue;

  assign out_valid = !w_fifo_empty;
  assign w_pop     = out_valid && out_ready;

  // Rows held plus rows in flight, after this cycle's pop. Keeping this
  // below two before issuing means a returning read always finds a slot.
  assign w_occ  = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_room = !w_fifo_full || w_pop;
  assign w_issue = (r_state == ST_RUN) && w_room && (w_occ < 3'd2);

  assign w_done       = (r_state == ST_DRAIN) && w_fifo_empty && !r_inflight;
  assign w_last_issue = (r_blk == 5'(N_BLK - 1)) && (r_row == 2'd3);

  assign w_issue_tag.row  = r_row;
  assign w_issue_tag.blk  = r_blk;
  assign w_issue_tag.ccin = (r_blk >= 5'(N_LUMA_BLK));
  assign w_issue_tag.last = w_last_issue;

  assign rd_en   = w_issue;
  assign rd_addr = blk_row_addr(r_blk, r_row);
  assign busy    = (r_state != ST_IDLE);
  assign done    = w_done;

  // Control FSM and the block/row walk counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_row   <= 2'd0;
      r_blk   <= 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_issue) begin
            if (r_row == 2'd3) begin
              r_row <= 2'd0;
              if (w_last_issue) begin
                r_blk   <= 5'd0;
                r_state <= ST_DRAIN;
              end else begin
                r_blk <= r_blk + 5'd1;
              end
            end else begin
              r_row <= r_row + 2'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // One-stage in-flight register: the tag waits here for the RAM data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_if_tag   <= '0;
    end else begin
      r_inflight <= w_issue;
      r_if_tag   <= w_issue_tag;
    end
  end

  mc_row_fifo #(
    .DATA_W (2 * ROW_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .i_push      (r_inflight),
    .i_push_data ({cur_rdata, ref_rdata}),
    .i_push_tag  (r_if_tag),
    .i_pop       (w_pop),
    .o_pop_data  (w_head_data),
    .o_pop_tag   (w_head_tag),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign out_cur  = w_head_data[2*ROW_W-1:ROW_W];
  assign out_ref  = w_head_data[ROW_W-1:0];
  assign out_row  = w_head_tag.row;
  assign out_blk  = w_head_tag.blk;
  assign out_ccin = w_head_tag.ccin;
  assign out_last = w_head_tag.last;

endmodule
`default_nettype wire

// File: tb/tb_mc_row_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_row_fetch
//  Brief    : Self-checking bench for mc_row_fetch with a buffer model and an
//             ordered-row reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_row_fetch;
  import mc_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ROW_W-1:0]  cur_rdata;
  logic [ROW_W-1:0]  ref_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ROW_W-1:0]  out_cur;
  logic [ROW_W-1:0]  out_ref;
  logic [1:0]        out_row;
  logic [4:0]        out_blk;
  logic              out_ccin;
  logic              out_last;

  mc_row_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .cur_rdata (cur_rdata),
    .ref_rdata (ref_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cur   (out_cur),
    .out_ref   (out_ref),
    .out_row   (out_row),
    .out_blk   (out_blk),
    .out_ccin  (out_ccin),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Row contents keyed by address so each row is recognisable downstream.
  function automatic logic [ROW_W-1:0] pat_cur(input logic [ADDR_W-1:0] a);
    return {4{1'b0, a}};
  endfunction

  function automatic logic [ROW_W-1:0] pat_ref(input logic [ADDR_W-1:0] a);
    return {4{1'b1, a}};
  endfunction

  // k-th row of the MB: block k/4, row k%4.
  function automatic logic [ADDR_W-1:0] exp_addr(input int k);
    return blk_row_addr(5'(k / 4), 2'(k % 4));
  endfunction

  // Buffer model: one-cycle read latency, junk when not reading.
  always @(posedge clk) begin
    if (rd_en) begin
      cur_rdata <= pat_cur(rd_addr);
      ref_rdata <= pat_ref(rd_addr);
    end else begin
      cur_rdata <= $urandom;
      ref_rdata <= $urandom;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor / scoreboard ----------------
  int                rd_idx = 0;
  int                hs_idx = 0;
  int                done_cnt = 0;
  int                done_total = 0;
  int                start_cyc = 0;
  int                first_valid_cyc = 0;
  int                done_cyc = 0;
  bit                seen_valid = 0;
  bit                prev_hold = 0;
  bit                chk_busy = 0;
  logic [63:0]       hold_data;
  logic [8:0]        hold_tag;
  logic [ADDR_W-1:0] m_a;
  logic [ADDR_W-1:0] rd_log [N_ROWS];

  always @(negedge clk) begin
    if (reset) begin
      rd_idx     = 0;
      hs_idx     = 0;
      done_cnt   = 0;
      seen_valid = 0;
      prev_hold  = 0;
      chk_busy   = 0;
    end else begin
      if (chk_busy) check_eq("busy_after_start", busy, 1);
      chk_busy = 0;
      if (start && !busy) begin
        rd_idx     = 0;
        hs_idx     = 0;
        done_cnt   = 0;
        seen_valid = 0;
        start_cyc  = cyc;
        chk_busy   = 1;
      end
      if (prev_hold) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", {out_cur, out_ref}, hold_data);
        check_eq("hold_tag", {out_blk, out_row, out_ccin, out_last}, hold_tag);
      end
      if (rd_en) begin
        if (rd_idx < N_ROWS) begin
          check_eq("rd_addr", rd_addr, exp_addr(rd_idx));
          rd_log[rd_idx] = rd_addr;
        end else begin
          check_eq("rd_extra", rd_idx, N_ROWS - 1);
        end
        rd_idx++;
      end
      if (out_valid && !seen_valid) begin
        seen_valid      = 1;
        first_valid_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (hs_idx < N_ROWS) begin
          m_a = exp_addr(hs_idx);
          check_eq("row_tag", {out_blk, out_row, out_ccin, out_last},
                   {5'(hs_idx / 4), 2'(hs_idx % 4), (hs_idx >= 64), (hs_idx == N_ROWS - 1)});
          check_eq("row_data", {out_cur, out_ref}, {pat_cur(m_a), pat_ref(m_a)});
        end else begin
          check_eq("row_extra", hs_idx, N_ROWS - 1);
        end
        hs_idx++;
      end
      if (rd_en) check_eq("occupancy_le2", (rd_idx - hs_idx) <= 2, 1);
      if (done) begin
        done_cnt++;
        done_total++;
        done_cyc = cyc;
        check_eq("done_all_rows", hs_idx, N_ROWS);
      end
      prev_hold = out_valid && !out_ready;
      hold_data = {out_cur, out_ref};
      hold_tag  = {out_blk, out_row, out_ccin, out_last};
    end
  end

  // ---------------- stimulus ----------------
  int mode = 0;       // 0: ready high, 1: ready low, 2: ready random
  bit poke_busy = 0;  // pulse start randomly while busy

  task automatic set_mode(input int m);
    mode = m;
    out_ready = (m == 1) ? 1'b0 : 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic start_mb();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (poke_busy) start = busy && !done && ($urandom_range(0, 7) == 0);
      if (done_cnt > 0) begin
        got = 1;
        break;
      end
    end
    start = 1'b0;
    check_eq("done_seen", got, 1);
  endtask

  task automatic finish_mb();
    repeat (3) step();
    check_eq("mb_rows", hs_idx, N_ROWS);
    check_eq("mb_reads", rd_idx, N_ROWS);
    check_eq("mb_done_once", done_cnt, 1);
    check_eq("mb_idle", busy, 0);
  endtask

  initial begin
    int d0;
    bit hit;
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd_en", rd_en, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_addr", rd_addr, 0);
    reset = 1'b0;
    step();

    // MB1: full-rate streaming, latency and address table
    set_mode(0);
    start_mb();
    wait_done(300);
    finish_mb();
    check_eq("lat_first_valid", first_valid_cyc - start_cyc, 3);
    check_eq("lat_done", done_cyc - start_cyc, 99);
    check_eq("addr_seq0", rd_log[0], 0);
    check_eq("addr_seq1", rd_log[1], 4);
    check_eq("addr_seq2", rd_log[2], 8);
    check_eq("addr_seq3", rd_log[3], 12);
    check_eq("addr_seq4", rd_log[4], 1);
    check_eq("addr_seq5", rd_log[5], 5);
    check_eq("addr_seq6", rd_log[6], 9);
    check_eq("addr_seq7", rd_log[7], 13);
    check_eq("addr_seq8", rd_log[8], 16);
    check_eq("addr_b5r2", rd_log[22], 11);
    check_eq("addr_b16r0", rd_log[64], 64);
    check_eq("addr_b23r3", rd_log[95], 95);

    // MB2: backpressure from the first row on
    set_mode(1);
    start_mb();
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        hit = 1;
        break;
      end
      step();
    end
    check_eq("bp_valid_seen", hit, 1);
    repeat (10) step();
    check_eq("bp_reads", rd_idx, 2);
    check_eq("bp_valid_held", out_valid, 1);
    set_mode(0);
    wait_done(300);
    finish_mb();

    // MB3: random ready, stray starts while busy
    set_mode(2);
    poke_busy = 1;
    start_mb();
    wait_done(1000);
    poke_busy = 0;
    finish_mb();

    // MB4: abort with reset part-way through
    set_mode(0);
    d0 = done_total;
    start_mb();
    for (int i = 0; i < 200; i++) begin
      if (hs_idx >= 40) break;
      step();
    end
    check_eq("abort_reached", hs_idx >= 40, 1);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    repeat (5) step();
    check_eq("abort_no_done", done_total, d0);
    check_eq("abort_idle", busy, 0);
    check_eq("abort_no_valid", out_valid, 0);
    check_eq("abort_addr0", rd_addr, 0);

    // MB5: fresh MB after abort, random ready
    set_mode(2);
    start_mb();
    wait_done(1000);
    finish_mb();
    check_eq("restart_addr0", rd_log[0], 0);

    // MB6: start coincident with done must be ignored
    set_mode(0);
    d0 = done_total;
    start_mb();
    hit = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (done) begin
        hit = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        break;
      end
    end
    check_eq("coinc_done_seen", hit, 1);
    repeat (5) step();
    check_eq("coinc_idle", busy, 0);
    check_eq("coinc_done_once", done_total, d0 + 1);
    check_eq("coinc_no_reads", rd_idx, N_ROWS);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_row_fetch.md
Name: mc_row_fetch

Overview:
- Upstream feeder for the inter motion-compensation controller.
- On `start`, walks one macroblock's sixteen 4x4 luma blocks and eight 4x4 chroma blocks in H.264 block-scan order.
- Reads each 4-pixel row from the current-MB buffer and the motion-compensated prediction buffer, which share one address.
- Presents rows over a valid/ready handshake, with row index and chroma flag. The MC controller consumes these as rows 0..3 of each block.

Parameters:
- PIX_W, 8, bits per pixel
- ROW_W, 32, bits per row word (4*PIX_W)
- N_LUMA_BLK, 16, luma 4x4 blocks per MB
- N_CHROMA_BLK, 8, chroma 4x4 blocks per MB (Cb 0-3, Cr 4-7)
- ADDR_W, 7, buffer address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin one MB; ignored while busy
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after final row handshake
- rd_en  out  1  read strobe to both buffers
- rd_addr  out  ADDR_W  shared read address
- cur_rdata  in  ROW_W  current-MB row, valid 1 cycle after rd_en
- ref_rdata  in  ROW_W  prediction row, valid 1 cycle after rd_en
- out_valid  out  1  row available
- out_ready  in  1  downstream accepts
- out_cur  out  ROW_W  current row pixels
- out_ref  out  ROW_W  prediction row pixels
- out_row  out  2  row within block, 0..3
- out_blk  out  5  block index, 0..23
- out_ccin  out  1  1 when out_blk>=16 (chroma)
- out_last  out  1  final row of MB (blk 23, row 3)

Behaviour:
- Reset is synchronous. It clears the state to IDLE, empties the FIFO, zeroes the counters and cancels in-flight reads.
- Reset values: busy=0, done=0, rd_en=0, out_valid=0, rd_addr=0. Data outputs are don't-care while out_valid=0.
- Reset mid-MB aborts: no done pulse is produced, and in-flight returned data is discarded.
- FSM states and transitions:
  - IDLE → RUN on start.
  - RUN → DRAIN when all 96 reads are issued.
  - DRAIN → IDLE when the FIFO is empty and no reads are in flight; done=1 for that one cycle.
  - A start arriving in the same cycle as done is ignored.
- Issue rule: in RUN, rd_en=1 iff (fifo_count + inflight − pop) < 2, where pop = out_valid && out_ready.
  - This guarantees no FIFO overflow.
  - With out_ready held at 1, it sustains 1 row/cycle.
- Issue order: a row counter r (0..3) runs inside a block counter b (0..23). r wraps 3→0 and increments b.
- Luma address (b<16): bx={b[2],b[0]}, by={b[3],b[1]}; addr=(by*4+r)*4+bx. Covers 0..63.
- Chroma address (b>=16): c=b−16, plane=c[2], bx=c[0], by=c[1]; addr=64+plane*16+(by*4+r)*2+bx. Covers 64..95.
- Each address 0..95 is read exactly once per MB.
- Tags: r, b, ccin and last travel with each read through a one-stage in-flight register and are written into the FIFO alongside the RAM data.
- Latency: start sampled at edge T → first rd_en in cycle T+1 → first out_valid in cycle T+3.
- With continuous ready: rows appear in cycles T+3..T+98; done in T+99.
- Handshake: once out_valid rises, out_valid and all out_* fields hold stable until out_ready. out_valid never depends on out_ready.
- Backpressure: with out_ready=0, at most 2 rows are buffered, and rd_en stays 0 once 2 rows are held or in flight.

Decomposition:
- Package mc_pkg holds:
  - the PIX_W, ROW_W and block-count constants;
  - LUMA_BASE=0, CB_BASE=64, CR_BASE=80;
  - a state enum type;
  - a function blk_row_addr(b,r) implementing the address mapping. The bench reuses it as the reference model.
- One sub-module, mc_row_fifo: a 2-entry FIFO carrying ROW_W*2 data plus a 9-bit tag (row, blk, ccin, last), with count, push, pop and full/empty.

Test Plan:
- Reset, then start with out_ready=1 → rd_addr sequence begins 0,4,8,12,1,5,9,13,16; blk 5 row 2 reads addr 11; blk 16 row 0 reads 64; blk 23 row 3 reads 95. out_valid first in T+3, done in T+99, 96 handshakes total.
- RAM returns data=addr pattern → out_cur/out_ref match blk_row_addr(out_blk,out_row). out_ccin=0 for blk 0..15 and 1 for 16..23. out_last=1 only on blk 23 row 3.
- Hold out_ready=0 for 10 cycles after the first out_valid → exactly 2 rd_en pulses total before stall; outputs stable; no row lost or duplicated on release.
- Random out_ready (50%) → 96 ordered rows, no overflow, done exactly once.
- Assert reset at row 40, then start again → no done from the aborted MB; the new MB restarts at addr 0, blk 0, row 0.
- Pulse start while busy and coincident with done → ignored; a single MB completes with a single done pulse.
